// File: rtl/ws2812_rx.sv
// ws2812_rx
//   Single-wire WS2812-style NRZ receiver. The raw line is synchronised,
//   every high pulse is classified as a 0 or 1 by its width, and the bits are
//   assembled MSB-first into 24-bit pixels and a frame buffer. A long low gap
//   closes the frame.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   din_i          raw data line, asynchronous to clk
//   pixel_data_o   last completed pixel, first-received bit at [23]
//   pixel_valid_o  1-cycle pulse when pixel_data_o updates
//   pixel_index_o  0-based index of the pixel in pixel_data_o (saturates at 255)
//   frame_o        frame buffer, first-received bit at [FW-1]
//   frame_done_o   1-cycle pulse: latch gap seen after at least one bit
//   frame_bits_o   bits received in the frame (saturates at FW), valid with frame_done_o
//   overflow_o     sticky: more than FW bits this frame; cleared by next frame's first bit
//   err_o          1-cycle pulse: glitch, stuck-high line, or partial pixel at frame end
module ws2812_rx #(
  parameter  int NUM_PIXELS   = 6,
  parameter  int BIT_THRESH   = 15,
  parameter  int MIN_HIGH     = 4,
  parameter  int MAX_HIGH     = 60,
  parameter  int RESET_CYCLES = 1200,
  localparam int FW           = 24 * NUM_PIXELS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_i,
  output logic [23:0]   pixel_data_o,
  output logic          pixel_valid_o,
  output logic [7:0]    pixel_index_o,
  output logic [FW-1:0] frame_o,
  output logic          frame_done_o,
  output logic [10:0]   frame_bits_o,
  output logic          overflow_o,
  output logic          err_o
);

  localparam logic [15:0] THR      = 16'(BIT_THRESH);
  localparam logic [15:0] MINH     = 16'(MIN_HIGH);
  localparam logic [15:0] MAXH     = 16'(MAX_HIGH);
  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [10:0] FWB      = 11'(FW);

  typedef enum logic [2:0] {
    WAIT_GAP  = 3'd0,
    IDLE      = 3'd1,
    HIGH      = 3'd2,
    LOW       = 3'd3,
    FRAME_END = 3'd4
  } state_t;

  state_t          state_q;
  logic            sync1_q;
  logic            ds_q;
  logic [15:0]     hcnt_q;
  logic [15:0]     lcnt_q;
  logic [23:0]     shift_q;
  logic [4:0]      pbit_q;
  logic [10:0]     bcnt_q;
  logic [7:0]      pidx_q;
  logic [23:0]     pixel_data_q;
  logic            pixel_valid_q;
  logic [7:0]      pixel_index_q;
  logic [FW-1:0]   frame_q;
  logic            frame_done_q;
  logic [10:0]     frame_bits_q;
  logic            overflow_q;
  logic            err_q;
  logic [23:0]     pix_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [10:0] sat_bits(input logic [10:0] v);
    return (v >= FWB) ? FWB : v + 11'd1;
  endfunction

  // Shift register contents once the bit ending on this cycle is appended.
  assign pix_d = {shift_q[22:0], (hcnt_q > THR)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_GAP;
      sync1_q       <= 1'b0;
      ds_q          <= 1'b0;
      hcnt_q        <= '0;
      lcnt_q        <= '0;
      shift_q       <= '0;
      pbit_q        <= '0;
      bcnt_q        <= '0;
      pidx_q        <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      frame_q       <= '0;
      frame_done_q  <= 1'b0;
      frame_bits_q  <= '0;
      overflow_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // Stage: two-flop synchroniser, ds_q is the sampled line.
      sync1_q       <= din_i;
      ds_q          <= sync1_q;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;

      // Stage: pulse classification and frame assembly.
      case (state_q)
        WAIT_GAP: begin
          // Only a full clean gap lets decoding start, so a frame is never
          // picked up mid-stream after reset or a stuck line.
          if (ds_q) begin
            lcnt_q <= '0;
          end else begin
            lcnt_q <= sat_inc16(lcnt_q);
            if (lcnt_q == RST_LAST) state_q <= IDLE;
          end
        end

        IDLE: begin
          bcnt_q <= '0;
          pbit_q <= '0;
          pidx_q <= '0;
          if (ds_q) begin
            hcnt_q  <= 16'd1;
            state_q <= HIGH;
          end
        end

        HIGH: begin
          if (ds_q) begin
            hcnt_q <= sat_inc16(hcnt_q);
            if (hcnt_q >= MAXH) begin
              err_q   <= 1'b1;
              lcnt_q  <= '0;
              state_q <= WAIT_GAP;
            end
          end else begin
            lcnt_q  <= '0;
            state_q <= LOW;
            if (hcnt_q < MINH) begin
              err_q <= 1'b1;
            end else begin
              shift_q <= pix_d;
              bcnt_q  <= sat_bits(bcnt_q);
              if (bcnt_q == 11'd0) overflow_q <= 1'b0;
              if (bcnt_q == FWB)   overflow_q <= 1'b1;
              if (pbit_q == 5'd23) begin
                pbit_q        <= '0;
                pixel_data_q  <= pix_d;
                pixel_valid_q <= 1'b1;
                pixel_index_q <= pidx_q;
                pidx_q        <= sat_inc8(pidx_q);
                // Pixels past the buffer still report but are not stored.
                for (int i = 0; i < NUM_PIXELS; i++) begin
                  if (pidx_q == 8'(i)) frame_q[FW-1-24*i -: 24] <= pix_d;
                end
              end else begin
                pbit_q <= pbit_q + 5'd1;
              end
            end
          end
        end

        LOW: begin
          if (ds_q) begin
            hcnt_q  <= 16'd1;
            state_q <= HIGH;
          end else begin
            lcnt_q <= sat_inc16(lcnt_q);
            if (lcnt_q == RST_LAST) state_q <= FRAME_END;
          end
        end

        FRAME_END: begin
          // A gap after only glitches carries no bits and reports nothing.
          if (bcnt_q != 11'd0) begin
            frame_done_q <= 1'b1;
            frame_bits_q <= bcnt_q;
            if (pbit_q != 5'd0) err_q <= 1'b1;
          end
          state_q <= IDLE;
        end

        default: state_q <= WAIT_GAP;
      endcase
    end
  end

  assign pixel_data_o  = pixel_data_q;
  assign pixel_valid_o = pixel_valid_q;
  assign pixel_index_o = pixel_index_q;
  assign frame_o       = frame_q;
  assign frame_done_o  = frame_done_q;
  assign frame_bits_o  = frame_bits_q;
  assign overflow_o    = overflow_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx
//   Directed bench for ws2812_rx. The stimulus tasks keep a reference model of
//   the decoder (shift register, bit and pixel counters, frame image) and push
//   the expected pixel and frame-done records onto queues before the line is
//   driven; a monitor pops and compares them when the DUT reports.
module tb_ws2812_rx;

  localparam int FW = 144;

  logic          clk = 1'b0;
  logic          rst;
  logic          din;
  logic [23:0]   pixel_data_o;
  logic          pixel_valid_o;
  logic [7:0]    pixel_index_o;
  logic [FW-1:0] frame_o;
  logic          frame_done_o;
  logic [10:0]   frame_bits_o;
  logic          overflow_o;
  logic          err_o;

  ws2812_rx dut (
    .clk           (clk),
    .rst           (rst),
    .din_i         (din),
    .pixel_data_o  (pixel_data_o),
    .pixel_valid_o (pixel_valid_o),
    .pixel_index_o (pixel_index_o),
    .frame_o       (frame_o),
    .frame_done_o  (frame_done_o),
    .frame_bits_o  (frame_bits_o),
    .overflow_o    (overflow_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0]   bits;
    logic [FW-1:0] frame;
    logic          err;
  } done_t;

  logic [31:0] pix_q[$];
  done_t       done_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int exp_err = 0;
  int exp_done = 0;

  // Reference model state
  logic [23:0]   m_sh;
  int            m_bits;
  int            m_idx;
  logic [FW-1:0] exp_frame;

  // Pulse timing for the current test
  int t_h1 = 21, t_l1 = 10, t_h0 = 11, t_l0 = 20;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: compares every DUT report against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (err_o) err_cnt++;
      if (pixel_valid_o) begin
        if (pix_q.size() == 0) begin
          check("unexpected_pixel_valid", 144'(pixel_valid_o), 144'(0));
        end else begin
          logic [31:0] e;
          e = pix_q.pop_front();
          check("pixel_data", 144'(pixel_data_o), 144'(e[23:0]));
          check("pixel_index", 144'(pixel_index_o), 144'(e[31:24]));
        end
      end
      if (frame_done_o) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          check("unexpected_frame_done", 144'(frame_done_o), 144'(0));
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("frame_bits", 144'(frame_bits_o), 144'(d.bits));
          check("frame", frame_o, d.frame);
          check("frame_end_err", 144'(err_o), 144'(d.err));
        end
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 200000 cycles, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    m_sh = '0;
    m_bits = 0;
    m_idx = 0;
  endtask

  // Model update happens before the pulse so the expectation is queued
  // ahead of the DUT report.
  task automatic send_bit(input logic b);
    m_sh = {m_sh[22:0], b};
    m_bits++;
    if (m_bits % 24 == 0) begin
      pix_q.push_back({8'(m_idx), m_sh});
      if (m_idx < 6) exp_frame[FW-1-24*m_idx -: 24] = m_sh;
      if (m_idx < 255) m_idx++;
    end
    if (b) drive(t_h1, t_l1);
    else   drive(t_h0, t_l0);
  endtask

  task automatic send_word(input logic [23:0] v, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(v[i]);
  endtask

  task automatic end_frame(input string tag);
    if (m_bits > 0) begin
      done_t d;
      d.bits  = (m_bits > FW) ? 11'(FW) : 11'(m_bits);
      d.frame = exp_frame;
      d.err   = (m_bits % 24) != 0;
      done_q.push_back(d);
      exp_done++;
      if (d.err) exp_err++;
    end
    gap(1300);
    model_clear();
    check({tag, "_pixels_drained"}, 144'(pix_q.size()), 144'(0));
    check({tag, "_done_drained"}, 144'(done_q.size()), 144'(0));
    check({tag, "_frame_done_count"}, 144'(done_cnt), 144'(exp_done));
    check({tag, "_err_count"}, 144'(err_cnt), 144'(exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel_data"}, 144'(pixel_data_o), 144'(0));
    check({tag, "_pixel_valid"}, 144'(pixel_valid_o), 144'(0));
    check({tag, "_pixel_index"}, 144'(pixel_index_o), 144'(0));
    check({tag, "_frame"}, frame_o, 144'(0));
    check({tag, "_frame_done"}, 144'(frame_done_o), 144'(0));
    check({tag, "_frame_bits"}, 144'(frame_bits_o), 144'(0));
    check({tag, "_overflow"}, 144'(overflow_o), 144'(0));
    check({tag, "_err"}, 144'(err_o), 144'(0));
  endtask

  initial begin
    din = 1'b0;
    rst = 1'b1;
    exp_frame = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    gap(1300);

    // 1) six pixels of FF0000 with nominal pulse widths
    for (int p = 0; p < 6; p++) send_word(24'hFF0000, 24);
    end_frame("t1");
    check("t1_frame_image", frame_o, {6{24'hFF0000}});

    // 2) widths exactly at the threshold: 15 high -> 0, 16 high -> 1
    t_h1 = 16; t_l1 = 15; t_h0 = 15; t_l0 = 16;
    for (int p = 0; p < 6; p++) send_word((p % 2 == 0) ? 24'hA5A5A5 : 24'h5A5A5A, 24);
    end_frame("t2");
    check("t2_frame_image", frame_o, {3{24'hA5A5A5, 24'h5A5A5A}});
    t_h1 = 21; t_l1 = 10; t_h0 = 11; t_l0 = 20;

    // 3) 2-cycle glitch between bits of pixel 0
    send_word(24'h123456, 10);
    drive(2, 12);
    exp_err++;
    send_word(24'h123456 << 10, 14);
    for (int p = 1; p < 6; p++) send_word(24'h0F0F0F + 24'(p), 24);
    end_frame("t3");

    // 4) seven pixels: overflow, last pixel reported but not stored
    for (int p = 0; p < 7; p++) send_word(24'h010203 * 24'(p + 1), 24);
    end_frame("t4");
    check("t4_overflow_set", 144'(overflow_o), 144'(1));

    // 5) 30 bits then gap: one pixel, partial-pixel error at frame end
    send_bit(1'b0);
    check("t5_overflow_cleared", 144'(overflow_o), 144'(0));
    send_word(24'h00FF00 << 1, 23);
    send_word(24'hA80000, 6);
    end_frame("t5");
    check("t5_frame_hold", frame_o[119:0], exp_frame[119:0]);

    // 5b) stuck-high line: error, no frame_done
    din = 1'b1;
    repeat (100) @(negedge clk);
    exp_err++;
    gap(1300);
    check("t5b_err_count", 144'(err_cnt), 144'(exp_err));
    check("t5b_frame_done_count", 144'(done_cnt), 144'(exp_done));

    // 6) reset after bit 50, then junk before a full gap is ignored
    send_word(24'hC0FFEE, 24);
    send_word(24'hBEEF01, 24);
    send_word(24'hC00000, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("t6_rst");
    check("t6_pixels_before_rst", 144'(pix_q.size()), 144'(0));
    rst = 1'b0;
    model_clear();
    exp_frame = '0;
    for (int i = 0; i < 24; i++) drive(21, 10);
    check("t6_no_decode_before_gap", 144'(pixel_index_o), 144'(0));
    check("t6_no_data_before_gap", 144'(pixel_data_o), 144'(0));
    gap(1300);
    for (int p = 0; p < 6; p++) send_word(24'h314159 ^ 24'(p * 7), 24);
    end_frame("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
